// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, scheduler state encoding and colour types.
package vga_timing_pkg;

  localparam int unsigned VGA_CLK_DIV      = 4;
  localparam int unsigned VGA_H_TOTAL      = 800;
  localparam int unsigned VGA_H_DISP_START = 144;
  localparam int unsigned VGA_H_DISP       = 640;
  localparam int unsigned VGA_V_TOTAL      = 521;
  localparam int unsigned VGA_V_DISP_START = 31;
  localparam int unsigned VGA_V_DISP       = 480;
  localparam int unsigned VGA_SCALE        = 5;

  localparam int unsigned CNT_W   = 12;
  localparam int unsigned IMG_W   = 7;
  localparam int unsigned COLOR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;

  typedef logic [3*COLOR_W-1:0] rgb_t;

endpackage

// File: rtl/vga_pix_divider.sv
// Pixel-rate divider: 2-bit phase counter with a one-clk pix_tick on the last phase.
module vga_pix_divider
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = VGA_CLK_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [1:0] phase,
  output logic       pix_tick
);

  localparam logic [1:0] LAST = 2'(CLK_DIV - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (!enable || phase == LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + 2'd1;
    end
  end

  assign pix_tick = enable && (phase == LAST);

endmodule

// File: rtl/vga_frame_scheduler.sv
// VGA timing master: pixel/line counters, 5x5 image ROM addressing and RGB output.
// Build macro TEST_PATTERN_EN replaces ROM pixels with 8 vertical colour bars.
module vga_frame_scheduler
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV      = VGA_CLK_DIV,
  parameter int unsigned H_TOTAL      = VGA_H_TOTAL,
  parameter int unsigned H_DISP_START = VGA_H_DISP_START,
  parameter int unsigned H_DISP       = VGA_H_DISP,
  parameter int unsigned V_TOTAL      = VGA_V_TOTAL,
  parameter int unsigned V_DISP_START = VGA_V_DISP_START,
  parameter int unsigned V_DISP       = VGA_V_DISP,
  parameter int unsigned SCALE        = VGA_SCALE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  output logic                 pix_tick,
  output logic [CNT_W-1:0]     H_count,
  output logic                 H_counter_enable,
  output logic [CNT_W-1:0]     V_count,
  output logic                 V_counter_enable,
  output logic                 frame_start,
  output logic                 display_active,
  output logic [2*IMG_W-1:0]   rom_addr,
  input  logic [3*COLOR_W-1:0] rom_data,
  output logic [COLOR_W-1:0]   vga_red,
  output logic [COLOR_W-1:0]   vga_green,
  output logic [COLOR_W-1:0]   vga_blue
);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_PRE   = CNT_W'(H_DISP_START - 1);
  localparam logic [CNT_W-1:0] H_FIRST = CNT_W'(H_DISP_START);
  localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_DISP_START + H_DISP - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_FIRST = CNT_W'(V_DISP_START);
  localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_DISP_START + V_DISP - 1);
  localparam logic [2:0]       SUB_LAST     = 3'(SCALE - 1);
  localparam logic [1:0]       SAMPLE_PHASE = 2'(CLK_DIV - 2);

  scan_state_e state, state_n;
  logic        scan_en;
  logic [1:0]  phase;
  logic        h_wrap, v_wrap;
  logic        h_adv;
  logic [2:0]  x_sub, y_sub;
  logic [IMG_W-1:0] x_img, y_img;
  rgb_t        pix_colour;
  rgb_t        rgb;

  assign scan_en = (state != ST_IDLE);

  vga_pix_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_divider (
    .clk      (clk),
    .reset    (reset),
    .enable   (scan_en),
    .phase    (phase),
    .pix_tick (pix_tick)
  );

  assign h_wrap           = pix_tick && (H_count == H_LAST);
  assign v_wrap           = h_wrap && (V_count == V_LAST);
  assign H_counter_enable = pix_tick;
  assign V_counter_enable = h_wrap;
  assign frame_start      = v_wrap;
  assign display_active   = (H_count >= H_FIRST) && (H_count <= H_END) &&
                            (V_count >= V_FIRST) && (V_count <= V_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (run) state_n = ST_SCAN;
      ST_SCAN:  if (!run) state_n = ST_DRAIN;
      ST_DRAIN: begin
        if (run)         state_n = ST_SCAN;
        else if (v_wrap) state_n = ST_IDLE;
      end
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      H_count <= '0;
      V_count <= '0;
    end else if (!scan_en) begin
      H_count <= '0;
      V_count <= '0;
    end else if (pix_tick) begin
      H_count <= h_wrap ? '0 : H_count + 12'd1;
      if (h_wrap) V_count <= v_wrap ? '0 : V_count + 12'd1;
    end
  end

  // Step only while the following column is still displayed; H_PRE rearms the line.
  assign h_adv = (H_count >= H_FIRST) && (H_count < H_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_sub <= '0;
      x_img <= '0;
      y_sub <= '0;
      y_img <= '0;
    end else if (!scan_en) begin
      x_sub <= '0;
      x_img <= '0;
      y_sub <= '0;
      y_img <= '0;
    end else begin
      if (pix_tick) begin
        if (H_count == H_PRE) begin
          x_sub <= '0;
          x_img <= '0;
        end else if (h_adv) begin
          if (x_sub == SUB_LAST) begin
            x_sub <= '0;
            x_img <= x_img + 7'd1;
          end else begin
            x_sub <= x_sub + 3'd1;
          end
        end
      end
      if (frame_start) begin
        y_sub <= '0;
        y_img <= '0;
      end else if (V_counter_enable && (V_count >= V_FIRST) && (V_count < V_END)) begin
        if (y_sub == SUB_LAST) begin
          y_sub <= '0;
          y_img <= y_img + 7'd1;
        end else begin
          y_sub <= y_sub + 3'd1;
        end
      end
    end
  end

  assign rom_addr = {y_img, x_img};

`ifdef TEST_PATTERN_EN
  localparam logic [6:0] BAR_LAST = 7'(H_DISP / 8 - 1);
  logic [6:0] bar_px;
  logic [2:0] bar_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (!scan_en) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (pix_tick) begin
      if (H_count == H_PRE) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (h_adv) begin
        if (bar_px == BAR_LAST) begin
          bar_px  <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_px <= bar_px + 7'd1;
        end
      end
    end
  end

  assign pix_colour = {{COLOR_W{bar_idx[2]}}, {COLOR_W{bar_idx[1]}}, {COLOR_W{bar_idx[0]}}};
`else
  assign pix_colour = rom_data;
`endif

  // ROM data for the current address is stable by SAMPLE_PHASE, so RGB lands inside the pixel period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb <= '0;
    end else if (!scan_en) begin
      rgb <= '0;
    end else if (phase == SAMPLE_PHASE) begin
      rgb <= display_active ? pix_colour : '0;
    end
  end

  assign {vga_red, vga_green, vga_blue} = rgb;

endmodule
